// File: rtl/soc_region_mc.sv
// soc_region_mc: multi-channel sense region.
// NUM_CH thermometer-coded tap words are synchronised, encoded to a tap
// position and measured over a 2^WIN_LOG2 cycle window. The per-channel
// {min, max, mean} record is committed one channel per cycle into an internal
// result memory that is read through a registered read port.
// Optional feature: define SOC_REGION_MC_ALARM_EN to add a sticky per-channel
// low-minimum alarm (ports alarm_thr_i / alarm_o).

module soc_region_mc #(
   parameter int unsigned NUM_CH      = 5,
   parameter int unsigned TAP_W       = 32,
   parameter int unsigned WIN_LOG2    = 10,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned ADDR_W      = 5,
   localparam int unsigned PW         = $clog2(TAP_W + 1),
   localparam int unsigned DATA_W     = 3 * PW
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable_i,
   input  logic [NUM_CH*TAP_W-1:0]   tap_i,
   input  logic                      rd_en_i,
   input  logic [ADDR_W-1:0]         rd_addr_i,
   output logic [DATA_W-1:0]         rd_data_o,
   output logic                      rd_valid_o,
   output logic                      busy_o,
   output logic                      window_done_o,
`ifdef SOC_REGION_MC_ALARM_EN
   output logic [7:0]                frame_cnt_o,
   input  logic [PW-1:0]             alarm_thr_i,
   output logic [NUM_CH-1:0]         alarm_o
`else
   output logic [7:0]                frame_cnt_o
`endif
);

   // Sum width is sized so that 2^WIN_LOG2 samples of TAP_W cannot overflow.
   localparam int unsigned SW = PW + WIN_LOG2;

   typedef enum logic [1:0] {
      StIdle,
      StClear,
      StMeasure,
      StCommit
   } state_e;

   state_e                  state;
   logic [WIN_LOG2-1:0]     win_cnt;
   logic [ADDR_W-1:0]       cidx;

   logic [NUM_CH*TAP_W-1:0] sync [SYNC_STAGES];
   logic [PW-1:0]           pos [NUM_CH];

   logic [PW-1:0]           ch_min [NUM_CH];
   logic [PW-1:0]           ch_max [NUM_CH];
   logic [SW-1:0]           ch_sum [NUM_CH];
   logic [DATA_W-1:0]       mem [NUM_CH];

   // Length of the unbroken run of ones starting at bit 0; anything above the
   // first zero is a bubble and is ignored.
   function automatic logic [PW-1:0] therm_pos(input logic [TAP_W-1:0] w);
      logic          run;
      logic [PW-1:0] p;
      run = 1'b1;
      p   = '0;
      for (int i = 0; i < TAP_W; i++) begin
         run = run & w[i];
         if (run) begin
            p = p + PW'(1);
         end
      end
      return p;
   endfunction

   // Tap synchroniser chain, cleared on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync[s] <= '0;
         end
      end else begin
         sync[0] <= tap_i;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync[s] <= sync[s-1];
         end
      end
   end

   // Encode every channel's synchronised tap word to a position.
   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         pos[k] = therm_pos(sync[SYNC_STAGES-1][k*TAP_W +: TAP_W]);
      end
   end

   // Window FSM with accumulators, result memory writes and registered status.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= StIdle;
         busy_o        <= 1'b0;
         window_done_o <= 1'b0;
         frame_cnt_o   <= '0;
         win_cnt       <= '0;
         cidx          <= '0;
         for (int k = 0; k < NUM_CH; k++) begin
            ch_min[k] <= '0;
            ch_max[k] <= '0;
            ch_sum[k] <= '0;
            mem[k]    <= '0;
         end
`ifdef SOC_REGION_MC_ALARM_EN
         alarm_o       <= '0;
`endif
      end else begin
         window_done_o <= 1'b0;
         unique case (state)
            StIdle: begin
               if (enable_i) begin
                  state  <= StClear;
                  busy_o <= 1'b1;
               end
            end

            StClear: begin
               if (!enable_i) begin
                  state  <= StIdle;
                  busy_o <= 1'b0;
               end else begin
                  for (int k = 0; k < NUM_CH; k++) begin
                     ch_min[k] <= PW'(TAP_W);
                     ch_max[k] <= '0;
                     ch_sum[k] <= '0;
                  end
                  win_cnt <= '0;
                  state   <= StMeasure;
               end
            end

            StMeasure: begin
               if (!enable_i) begin
                  // Abort leaves memory and frame count untouched.
                  state  <= StIdle;
                  busy_o <= 1'b0;
               end else begin
                  for (int k = 0; k < NUM_CH; k++) begin
                     if (pos[k] < ch_min[k]) begin
                        ch_min[k] <= pos[k];
                     end
                     if (pos[k] > ch_max[k]) begin
                        ch_max[k] <= pos[k];
                     end
                     ch_sum[k] <= ch_sum[k] + SW'(pos[k]);
                  end
                  win_cnt <= win_cnt + WIN_LOG2'(1);
                  if (win_cnt == '1) begin
                     state <= StCommit;
                     cidx  <= '0;
                  end
               end
            end

            StCommit: begin
               // One channel per cycle; enable_i is ignored until the last write.
               for (int k = 0; k < NUM_CH; k++) begin
                  if (cidx == ADDR_W'(k)) begin
                     mem[k] <= {ch_min[k], ch_max[k], PW'(ch_sum[k] >> WIN_LOG2)};
`ifdef SOC_REGION_MC_ALARM_EN
                     if (ch_min[k] < alarm_thr_i) begin
                        alarm_o[k] <= 1'b1;
                     end
`endif
                  end
               end
               if (cidx == ADDR_W'(NUM_CH - 1)) begin
                  window_done_o <= 1'b1;
                  frame_cnt_o   <= frame_cnt_o + 8'd1;
                  if (enable_i) begin
                     state <= StClear;
                  end else begin
                     state  <= StIdle;
                     busy_o <= 1'b0;
                  end
               end else begin
                  cidx <= cidx + ADDR_W'(1);
               end
            end

            default: begin
               state  <= StIdle;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

   // Registered read port; out-of-range addresses return zero. A read that
   // collides with a commit write sees the pre-write contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_o  <= '0;
         rd_valid_o <= 1'b0;
      end else begin
         rd_valid_o <= rd_en_i;
         if (rd_en_i) begin
            rd_data_o <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
               if (rd_addr_i == ADDR_W'(k)) begin
                  rd_data_o <= mem[k];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_soc_region_mc.sv
// Directed self-checking bench for soc_region_mc (NUM_CH=5, TAP_W=32,
// WIN_LOG2=4). Build with SOC_REGION_MC_ALARM_EN defined to also cover alarms.

module tb_soc_region_mc;

   localparam int NUM_CH   = 5;
   localparam int TAP_W    = 32;
   localparam int WIN_LOG2 = 4;
   localparam int ADDR_W   = 5;
   localparam int PW       = 6;
   localparam int DATA_W   = 18;
   // Cycles from CLEAR entry to the done pulse, and the back-to-back period.
   localparam int WIN_CYC  = 1 + (1 << WIN_LOG2) + NUM_CH;

   logic                    clk;
   logic                    rst;
   logic                    enable;
   logic [NUM_CH*TAP_W-1:0] tap;
   logic                    rd_en;
   logic [ADDR_W-1:0]       rd_addr;
   logic [DATA_W-1:0]       rd_data;
   logic                    rd_valid;
   logic                    busy;
   logic                    done;
   logic [7:0]              frame;
`ifdef SOC_REGION_MC_ALARM_EN
   logic [PW-1:0]           alarm_thr;
   logic [NUM_CH-1:0]       alarm;
`endif

   int  n_assert = 0;
   int  n_fail   = 0;
   bit  alt      = 1'b0;

   soc_region_mc #(
      .NUM_CH     (NUM_CH),
      .TAP_W      (TAP_W),
      .WIN_LOG2   (WIN_LOG2),
      .SYNC_STAGES(2),
      .ADDR_W     (ADDR_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable_i     (enable),
      .tap_i        (tap),
      .rd_en_i      (rd_en),
      .rd_addr_i    (rd_addr),
      .rd_data_o    (rd_data),
      .rd_valid_o   (rd_valid),
      .busy_o       (busy),
      .window_done_o(done),
`ifdef SOC_REGION_MC_ALARM_EN
      .frame_cnt_o  (frame),
      .alarm_thr_i  (alarm_thr),
      .alarm_o      (alarm)
`else
      .frame_cnt_o  (frame)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] rec(input int mn, input int mx, input int mean);
      return {6'(mn), 6'(mx), 6'(mean)};
   endfunction

   function automatic logic [31:0] therm(input int n);
      logic [32:0] w;
      w = (33'd1 << n) - 33'd1;
      return w[31:0];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit
   // after the edge. Channel 0 optionally toggles between 0xF and 0xFF.
   task automatic step();
      @(posedge clk);
      #1;
      if (alt) tap[31:0] = tap[31:0] ^ 32'h0000_00F0;
   endtask

   task automatic rd(input int addr, input logic [DATA_W-1:0] exp, input string tag);
      rd_en   = 1'b1;
      rd_addr = ADDR_W'(addr);
      step();
      chk({tag, "_valid"}, 64'(rd_valid), 64'd1);
      chk({tag, "_data"}, 64'(rd_data), 64'(exp));
      rd_en = 1'b0;
   endtask

   // Runs one window from IDLE. drop_at drops enable after that cycle index;
   // probe issues a read of address 0 in the cycle that commits channel 0.
   task automatic run_window(input int drop_at, input bit probe,
                             input logic [DATA_W-1:0] probe_exp, output int done_at);
      bit seen;
      seen    = 1'b0;
      done_at = -1;
      enable  = 1'b1;
      step();
      chk("busy_clear", 64'(busy), 64'd1);
      for (int n = 1; n <= 3 * WIN_CYC; n++) begin
         step();
         if (probe && n == 2 + (1 << WIN_LOG2)) begin
            chk("coll_valid", 64'(rd_valid), 64'd1);
            chk("coll_old_data", 64'(rd_data), 64'(probe_exp));
            rd_en = 1'b0;
         end
         if (done) begin
            done_at = n;
            seen    = 1'b1;
            break;
         end
         if (n == drop_at) enable = 1'b0;
         if (probe && n == 1 + (1 << WIN_LOG2)) begin
            rd_en   = 1'b1;
            rd_addr = '0;
         end
      end
      enable = 1'b0;
      if (!seen) begin
         n_assert++;
         n_fail++;
         $error("FAIL done_timeout: observed none expected pulse");
      end
      step();
      chk("done_one_cycle", 64'(done), 64'd0);
      step();
      chk("busy_after_win", 64'(busy), 64'd0);
   endtask

   initial begin
      int         d;
      int         t [3];
      int         nd;
      int         cyc;
      bit         any_done;

      rst     = 1'b1;
      enable  = 1'b0;
      tap     = '0;
      rd_en   = 1'b0;
      rd_addr = '0;
`ifdef SOC_REGION_MC_ALARM_EN
      alarm_thr = 6'd10;
`endif
      repeat (3) step();
      rst = 1'b0;

      // Reset state.
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_frame", 64'(frame), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_rd_valid", 64'(rd_valid), 64'd0);
`ifdef SOC_REGION_MC_ALARM_EN
      chk("rst_alarm", 64'(alarm), 64'd0);
`endif
      for (int a = 0; a < NUM_CH; a++) rd(a, '0, "rst_rd");
      step();
      chk("rd_idle_valid", 64'(rd_valid), 64'd0);

      // Window 1: channel k at position 8+k.
      for (int k = 0; k < NUM_CH; k++) tap[k*TAP_W +: TAP_W] = therm(8 + k);
      repeat (4) step();
      run_window(0, 1'b0, '0, d);
      chk("w1_done_latency", 64'(d), 64'(WIN_CYC));
      chk("w1_frame", 64'(frame), 64'd1);
      for (int k = 0; k < NUM_CH; k++) rd(k, rec(8 + k, 8 + k, 8 + k), "w1_rd");
      step();
      chk("rd_hold_valid", 64'(rd_valid), 64'd0);
      chk("rd_hold_data", 64'(rd_data), 64'(rec(12, 12, 12)));

      // Window 2: alternating ch0, bubble ch1, full/empty ch2/ch3, ch4 at 3.
      tap[0*TAP_W +: TAP_W] = 32'h0000_000F;
      tap[1*TAP_W +: TAP_W] = 32'hFFFF_00FF;
      tap[2*TAP_W +: TAP_W] = 32'hFFFF_FFFF;
      tap[3*TAP_W +: TAP_W] = 32'h0000_0000;
      tap[4*TAP_W +: TAP_W] = 32'h0000_0007;
      alt = 1'b1;
      repeat (4) step();
      run_window(0, 1'b1, rec(8, 8, 8), d);
      alt = 1'b0;
      chk("w2_done_latency", 64'(d), 64'(WIN_CYC));
      chk("w2_frame", 64'(frame), 64'd2);
      rd(0, rec(4, 8, 6), "w2_ch0_alt");
      rd(1, rec(8, 8, 8), "w2_ch1_bubble");
      rd(2, rec(32, 32, 32), "w2_ch2_ones");
      rd(3, rec(0, 0, 0), "w2_ch3_zeros");
      rd(4, rec(3, 3, 3), "w2_ch4");
      rd(7, '0, "w2_oob7");
      rd(31, '0, "w2_oob31");

      // Abort during MEASURE: memory, frame count and done are untouched.
      for (int k = 0; k < NUM_CH; k++) tap[k*TAP_W +: TAP_W] = 32'hFFFF_FFFF;
      repeat (4) step();
      any_done = 1'b0;
      enable   = 1'b1;
      step();
      for (int n = 1; n <= 10; n++) begin
         step();
         if (done) any_done = 1'b1;
      end
      enable = 1'b0;
      step();
      if (done) any_done = 1'b1;
      step();
      if (done) any_done = 1'b1;
      chk("abort_busy", 64'(busy), 64'd0);
      repeat (30) begin
         step();
         if (done) any_done = 1'b1;
      end
      chk("abort_no_done", 64'(any_done), 64'd0);
      chk("abort_frame", 64'(frame), 64'd2);
      rd(0, rec(4, 8, 6), "abort_ch0");
      rd(4, rec(3, 3, 3), "abort_ch4");

      // Reset mid-window clears memory and frame count.
      enable = 1'b1;
      repeat (8) step();
      chk("mid_busy", 64'(busy), 64'd1);
      rst    = 1'b1;
      enable = 1'b0;
      step();
      rst = 1'b0;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_frame", 64'(frame), 64'd0);
      rd(2, '0, "midrst_ch2");

      // Three back-to-back windows.
      tap[0*TAP_W +: TAP_W] = therm(10);
      tap[1*TAP_W +: TAP_W] = therm(9);
      for (int k = 2; k < NUM_CH; k++) tap[k*TAP_W +: TAP_W] = therm(20);
      repeat (4) step();
      nd     = 0;
      enable = 1'b1;
      for (cyc = 1; cyc <= 5 * WIN_CYC; cyc++) begin
         step();
         if (done) begin
            t[nd] = cyc;
            nd++;
            if (nd == 3) break;
         end
      end
      enable = 1'b0;
      chk("b2b_count", 64'(nd), 64'd3);
      if (nd == 3) begin
         chk("b2b_first", 64'(t[0]), 64'(WIN_CYC + 1));
         chk("b2b_gap1", 64'(t[1] - t[0]), 64'(WIN_CYC));
         chk("b2b_gap2", 64'(t[2] - t[1]), 64'(WIN_CYC));
      end
      repeat (3) step();
      chk("b2b_frame", 64'(frame), 64'd3);
      chk("b2b_busy", 64'(busy), 64'd0);
      rd(0, rec(10, 10, 10), "b2b_ch0");
      rd(1, rec(9, 9, 9), "b2b_ch1");
`ifdef SOC_REGION_MC_ALARM_EN
      chk("alarm_set", 64'(alarm), 64'h02);
`endif

      // Enable dropped during COMMIT: commit finishes, then IDLE.
      tap[1*TAP_W +: TAP_W] = therm(20);
      repeat (4) step();
      run_window(3 + (1 << WIN_LOG2), 1'b0, '0, d);
      chk("cdrop_done_latency", 64'(d), 64'(WIN_CYC));
      chk("cdrop_frame", 64'(frame), 64'd4);
      rd(1, rec(20, 20, 20), "cdrop_ch1");
`ifdef SOC_REGION_MC_ALARM_EN
      chk("alarm_sticky", 64'(alarm), 64'h02);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("alarm_rst", 64'(alarm), 64'h00);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
